// File: rtl/branch_resolver_pkg.sv
// Shared types and widths for the execute-stage branch resolver.
// Holds the resolver state encodings and the delay-slot fall-through helper.
package branch_resolver_pkg;

  localparam int ADDR_W = 32;
  localparam int GHR_W  = 8;

  typedef enum logic [1:0] {
    BR_ST_IDLE    = 2'd0,
    BR_ST_WAIT_DS = 2'd1,
    BR_ST_FLUSH   = 2'd2
  } br_state_e;

  // Not-taken redirect skips the branch and its delay slot.
  function automatic logic [ADDR_W-1:0] br_fallthrough(input logic [ADDR_W-1:0] pc);
    return pc + 32'd8;
  endfunction

endpackage

// File: rtl/branch_stat_counter.sv
// Resolved-branch and misprediction counters (32-bit, wrapping).
// Only instantiated when BRANCH_STAT_EN is defined.
module branch_stat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept_i,
  input  logic        miss_i,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_misses_o
);

  logic [31:0] branches_q, branches_d;
  logic [31:0] misses_q, misses_d;

  always_comb begin
    branches_d = branches_q;
    misses_d   = misses_q;
    if (accept_i) begin
      branches_d = branches_q + 32'd1;
      misses_d   = miss_i ? (misses_q + 32'd1) : misses_q;
    end else begin
      branches_d = branches_q;
      misses_d   = misses_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branches_q <= 32'd0;
      misses_q   <= 32'd0;
    end else begin
      branches_q <= branches_d;
      misses_q   <= misses_d;
    end
  end

  assign stat_branches_o = branches_q;
  assign stat_misses_o   = misses_q;

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: predictor update strobe plus mispredict flush/redirect.
// Optional statistics counters are enabled with the BRANCH_STAT_EN macro.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc00000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush_in,
  input  logic              is_branch_in,
  input  logic              is_jump_in,
  input  logic              cond_taken_in,
  input  logic              pred_taken_in,
  input  logic [ADDR_W-1:0] pred_target_in,
  input  logic [GHR_W-1:0]  pht_index_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] target_in,
  input  logic              ds_in_pipe,
  output logic              is_branch_out,
  output logic              is_jump_out,
  output logic              is_taken_out,
  output logic [GHR_W-1:0]  last_pht_index,
  output logic [ADDR_W-1:0] inst_pc_out,
  output logic [ADDR_W-1:0] target_out,
  output logic              flush,
  output logic [ADDR_W-1:0] exc_pc,
`ifdef BRANCH_STAT_EN
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_misses,
`endif
  output logic              busy
);

  br_state_e         state_q;
  logic              accept_s, taken_s, miss_s;
  logic [ADDR_W-1:0] redir_s;

  logic              upd_q, jump_q, taken_q, flush_q, busy_q;
  logic [GHR_W-1:0]  pht_q;
  logic [ADDR_W-1:0] pc_q, target_q, exc_pc_q, redir_q;

  always_comb begin
    taken_s  = is_jump_in | cond_taken_in;
    miss_s   = (taken_s != pred_taken_in) |
               (taken_s & pred_taken_in & (pred_target_in != target_in));
    redir_s  = taken_s ? target_in : br_fallthrough(pc_in);
    accept_s = valid_in & is_branch_in & ~stall & ~flush_in & (state_q == BR_ST_IDLE);
  end

  // Update strobe fires only the cycle after accept; fields hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_q    <= 1'b0;
      jump_q   <= 1'b0;
      taken_q  <= 1'b0;
      pht_q    <= '0;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
    end else if (accept_s) begin
      upd_q    <= 1'b1;
      jump_q   <= is_jump_in;
      taken_q  <= taken_s;
      pht_q    <= pht_index_in;
      pc_q     <= pc_in;
      target_q <= target_in;
    end else begin
      upd_q    <= 1'b0;
    end
  end

  // External flush overrides everything and drops any pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BR_ST_IDLE;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
      exc_pc_q <= RESET_PC;
      redir_q  <= RESET_PC;
    end else if (flush_in) begin
      state_q  <= BR_ST_IDLE;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        BR_ST_IDLE: begin
          if (accept_s && miss_s && ds_in_pipe) begin
            state_q  <= BR_ST_FLUSH;
            flush_q  <= 1'b1;
            busy_q   <= 1'b1;
            exc_pc_q <= redir_s;
          end else if (accept_s && miss_s) begin
            state_q  <= BR_ST_WAIT_DS;
            flush_q  <= 1'b0;
            busy_q   <= 1'b1;
            redir_q  <= redir_s;
          end else begin
            state_q  <= BR_ST_IDLE;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        BR_ST_WAIT_DS: begin
          if (ds_in_pipe) begin
            state_q  <= BR_ST_FLUSH;
            flush_q  <= 1'b1;
            exc_pc_q <= redir_q;
          end else begin
            state_q  <= BR_ST_WAIT_DS;
            flush_q  <= 1'b0;
          end
          busy_q <= 1'b1;
        end
        BR_ST_FLUSH: begin
          state_q <= BR_ST_IDLE;
          flush_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= BR_ST_IDLE;
          flush_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STAT_EN
  branch_stat_counter u_stat (
    .clk             (clk),
    .rst             (rst),
    .accept_i        (accept_s),
    .miss_i          (miss_s),
    .stat_branches_o (stat_branches),
    .stat_misses_o   (stat_misses)
  );
`endif

  assign is_branch_out  = upd_q;
  assign is_jump_out    = jump_q;
  assign is_taken_out   = taken_q;
  assign last_pht_index = pht_q;
  assign inst_pc_out    = pc_q;
  assign target_out     = target_q;
  assign flush          = flush_q;
  assign exc_pc         = exc_pc_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios followed by random traffic
// checked against a pending-redirect reference model (stats checked when BRANCH_STAT_EN is defined).
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  localparam logic [31:0] RPC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        rst, valid_in, stall, flush_in, is_branch_in, is_jump_in;
  logic        cond_taken_in, pred_taken_in, ds_in_pipe;
  logic [31:0] pred_target_in, pc_in, target_in;
  logic [7:0]  pht_index_in;
  logic        is_branch_out, is_jump_out, is_taken_out, flush, busy;
  logic [7:0]  last_pht_index;
  logic [31:0] inst_pc_out, target_out, exc_pc;
`ifdef BRANCH_STAT_EN
  logic [31:0] stat_branches, stat_misses;
`endif

  always #5 clk = ~clk;

  branch_resolver dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush_in(flush_in),
    .is_branch_in(is_branch_in), .is_jump_in(is_jump_in), .cond_taken_in(cond_taken_in),
    .pred_taken_in(pred_taken_in), .pred_target_in(pred_target_in),
    .pht_index_in(pht_index_in), .pc_in(pc_in), .target_in(target_in),
    .ds_in_pipe(ds_in_pipe), .is_branch_out(is_branch_out), .is_jump_out(is_jump_out),
    .is_taken_out(is_taken_out), .last_pht_index(last_pht_index),
    .inst_pc_out(inst_pc_out), .target_out(target_out), .flush(flush), .exc_pc(exc_pc),
`ifdef BRANCH_STAT_EN
    .stat_branches(stat_branches), .stat_misses(stat_misses),
`endif
    .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a pending redirect waits for the delay slot, then flushes for one cycle.
  bit          m_pend, m_flush, m_upd, m_jmp, m_tkn;
  logic [7:0]  m_pht;
  logic [31:0] m_pc, m_tgt, m_exc, m_pend_pc, m_nbr, m_nmiss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_flush = 0; m_upd = 0; m_jmp = 0; m_tkn = 0;
    m_pht = 8'd0; m_pc = RPC; m_tgt = RPC; m_exc = RPC; m_pend_pc = RPC;
    m_nbr = 32'd0; m_nmiss = 32'd0;
  endtask

  task automatic model_edge();
    bit acc, tk, ms;
    logic [31:0] rd;
    if (rst) begin
      model_reset();
    end else begin
      acc = valid_in && is_branch_in && !stall && !flush_in && !m_pend && !m_flush;
      tk  = is_jump_in || cond_taken_in;
      ms  = (tk != pred_taken_in) || (tk && pred_taken_in && pred_target_in != target_in);
      rd  = tk ? target_in : pc_in + 32'd8;
      m_upd = acc;
      if (acc) begin
        m_jmp = is_jump_in; m_tkn = tk; m_pht = pht_index_in;
        m_pc = pc_in; m_tgt = target_in;
        m_nbr = m_nbr + 32'd1;
        if (ms) m_nmiss = m_nmiss + 32'd1;
      end
      if (m_flush) m_flush = 0;
      else if (flush_in) m_pend = 0;
      else if (m_pend) begin
        if (ds_in_pipe) begin m_flush = 1; m_exc = m_pend_pc; m_pend = 0; end
      end else if (acc && ms) begin
        if (ds_in_pipe) begin m_flush = 1; m_exc = rd; end
        else begin m_pend = 1; m_pend_pc = rd; end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("upd",   32'(is_branch_out), 32'(m_upd));
    check("jump",  32'(is_jump_out),   32'(m_jmp));
    check("taken", 32'(is_taken_out),  32'(m_tkn));
    check("pht",   32'(last_pht_index), 32'(m_pht));
    check("pc",    inst_pc_out, m_pc);
    check("tgt",   target_out,  m_tgt);
    check("flush", 32'(flush),  32'(m_flush));
    if (m_flush) check("exc_pc", exc_pc, m_exc);
    check("busy",  32'(busy),   32'(m_pend || m_flush));
`ifdef BRANCH_STAT_EN
    check("stat_br",   stat_branches, m_nbr);
    check("stat_miss", stat_misses,   m_nmiss);
`endif
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] ptgt,
                         input logic jmp, input logic cond, input logic pred, input logic ds);
    valid_in = 1'b1; is_branch_in = 1'b1; stall = 1'b0; flush_in = 1'b0;
    pc_in = pc; target_in = tgt; pred_target_in = ptgt;
    is_jump_in = jmp; cond_taken_in = cond; pred_taken_in = pred; ds_in_pipe = ds;
    pht_index_in = 8'($urandom);
  endtask

  task automatic idle(input logic ds);
    valid_in = 1'b0; is_branch_in = 1'b0; ds_in_pipe = ds; flush_in = 1'b0; stall = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; valid_in = 1'b0; stall = 1'b0; flush_in = 1'b0; is_branch_in = 1'b0;
    is_jump_in = 1'b0; cond_taken_in = 1'b0; pred_taken_in = 1'b0; ds_in_pipe = 1'b0;
    pred_target_in = 32'd0; pc_in = 32'd0; target_in = 32'd0; pht_index_in = 8'd0;
    step(); step();
    check("rst_exc", exc_pc, RPC);
    check("rst_pc",  inst_pc_out, RPC);
    check("rst_flush", 32'(flush), 32'd0);
    rst = 1'b0;

    // 1: correct not-taken
    present(32'hbfc00010, 32'hbfc00100, 32'hbfc00100, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("s1_upd", 32'(is_branch_out), 32'd1);
    check("s1_taken", 32'(is_taken_out), 32'd0);
    idle(1'b1); step();
    check("s1_upd_off", 32'(is_branch_out), 32'd0);
    check("s1_noflush", 32'(flush), 32'd0);

    // 2: taken miss, delay slot already present
    present(32'hbfc00020, RPC, RPC, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    check("s2_flush", 32'(flush), 32'd1);
    check("s2_exc", exc_pc, 32'hbfc00000);
    idle(1'b1); step();
    check("s2_flush_off", 32'(flush), 32'd0);

    // 3: not-taken miss, delay slot late; second branch ignored
    present(32'hbfc00010, 32'hbfc00200, 32'hbfc00200, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    present(32'hbfc00300, 32'hbfc00400, 32'hbfc00400, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    idle(1'b0); step();
    check("s3_busy", 32'(busy), 32'd1);
    check("s3_ignored", 32'(is_branch_out), 32'd0);
    idle(1'b1); step();
    check("s3_flush", 32'(flush), 32'd1);
    check("s3_exc", exc_pc, 32'hbfc00018);
    idle(1'b0); step();

    // 4: jump with wrong predicted target
    present(32'hbfc00030, 32'hbfc00080, 32'hbfc00040, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    check("s4_flush", 32'(flush), 32'd1);
    check("s4_exc", exc_pc, 32'hbfc00080);
    check("s4_jump", 32'(is_jump_out), 32'd1);
    idle(1'b0); step();
`ifdef BRANCH_STAT_EN
    check("s6_br", stat_branches, 32'd4);
    check("s6_miss", stat_misses, 32'd3);
`endif

    // 5: external flush while waiting for the delay slot, then stall
    present(32'hbfc00050, 32'hbfc00500, 32'hbfc00500, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    idle(1'b0); flush_in = 1'b1; step();
    check("s5_idle", 32'(busy), 32'd0);
    idle(1'b1); step(); step();
    check("s5_noflush", 32'(flush), 32'd0);
    present(32'hbfc00060, 32'hbfc00600, 32'hbfc00600, 1'b0, 1'b1, 1'b1, 1'b0);
    stall = 1'b1; step(); step();
    check("s5_stalled", 32'(is_branch_out), 32'd0);
    stall = 1'b0; step();
    check("s5_released", 32'(is_branch_out), 32'd1);
    idle(1'b0); step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 299) == 0);
      valid_in       = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 4) == 0);
      flush_in       = ($urandom_range(0, 14) == 0);
      is_branch_in   = 1'($urandom_range(0, 1));
      is_jump_in     = ($urandom_range(0, 3) == 0);
      cond_taken_in  = 1'($urandom_range(0, 1));
      pred_taken_in  = 1'($urandom_range(0, 1));
      ds_in_pipe     = ($urandom_range(0, 2) == 0);
      pht_index_in   = 8'($urandom);
      pc_in          = ($urandom_range(0, 19) == 0) ? 32'hfffffffc : ($urandom & 32'hfffffffc);
      target_in      = RPC + 32'($urandom_range(0, 3)) * 32'd16;
      pred_target_in = RPC + 32'($urandom_range(0, 3)) * 32'd16;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
